// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, default rule masks and popcount for the life row engine
package life_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_LAST
    } state_t;

    localparam logic [8:0] CONWAY_BIRTH   = 9'b000001000;
    localparam logic [8:0] CONWAY_SURVIVE = 9'b000001100;

    // Rows are zero-extended to this width before counting.
    localparam int POP_MAX = 1024;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/life_rule_cell.sv
// rtl/life_rule_cell.sv - next state of one cell from its 3x3 window and the birth/survive masks
module life_rule_cell (
    input  logic [8:0] window,
    input  logic [8:0] birth_mask,
    input  logic [8:0] survive_mask,
    output logic       next
);

    // window[2:0] row above, [5:3] own row, [8:6] row below; bit 4 is the cell itself
    logic [3:0] n;

    always_comb begin
        n = '0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) n = n + {3'b000, window[i]};
        end
        next = window[4] ? survive_mask[n] : birth_mask[n];
    end

endmodule

// File: rtl/life_row_engine.sv
// rtl/life_row_engine.sv - streaming next-generation engine over a three-row window
module life_row_engine
    import life_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 32,
    parameter int WRAP   = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [8:0]                           birth_mask,
    input  logic [8:0]                           survive_mask,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_row,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     out_row,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 gen_done,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    alive_count,
    output logic                                 stable
);

    localparam int CW = $clog2(WIDTH*HEIGHT+1);
    localparam int RW = $clog2(HEIGHT+1);

    state_t           state, state_nxt;
    logic [8:0]       birth_q, survive_q;
    logic [WIDTH-1:0] prev_row, cur_row, below_row, new_row;
    logic [WIDTH+1:0] ext_p, ext_c, ext_b;
    logic [RW-1:0]    row_cnt;
    logic             out_free, start_go, fill_acc, load_run, load_drain, last_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_go)                                state_nxt = S_FILL;
            S_FILL:  if (fill_acc)                                state_nxt = S_RUN;
            S_RUN:   if (load_run && row_cnt == RW'(HEIGHT - 1))  state_nxt = S_DRAIN;
            S_DRAIN: if (load_drain)                              state_nxt = S_LAST;
            S_LAST:  if (last_hs)                                 state_nxt = S_IDLE;
            default:                                              state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_free = !out_valid || out_ready;
        in_ready = 1'b0;
        case (state)
            S_FILL:  in_ready = 1'b1;
            S_RUN:   in_ready = out_free;
            default: in_ready = 1'b0;
        endcase
        busy       = (state != S_IDLE);
        start_go   = (state == S_IDLE) && start;
        fill_acc   = (state == S_FILL) && in_valid;
        load_run   = (state == S_RUN) && in_valid && in_ready;
        load_drain = (state == S_DRAIN) && out_free;
        last_hs    = (state == S_LAST) && out_valid && out_ready;
    end

    // Bottom grid edge: the row below the last one is dead.
    assign below_row = (state == S_DRAIN) ? '0 : in_row;

    // One guard column on each side holds the wrapped neighbour or a dead cell.
    generate
        if (WRAP != 0) begin : g_wrap
            assign ext_p = {prev_row[0],  prev_row,  prev_row[WIDTH-1]};
            assign ext_c = {cur_row[0],   cur_row,   cur_row[WIDTH-1]};
            assign ext_b = {below_row[0], below_row, below_row[WIDTH-1]};
        end else begin : g_zero
            assign ext_p = {1'b0, prev_row,  1'b0};
            assign ext_c = {1'b0, cur_row,   1'b0};
            assign ext_b = {1'b0, below_row, 1'b0};
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        life_rule_cell u_cell (
            .window      ({ext_b[i+2:i], ext_c[i+2:i], ext_p[i+2:i]}),
            .birth_mask  (birth_q),
            .survive_mask(survive_q),
            .next        (new_row[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            birth_q     <= CONWAY_BIRTH;
            survive_q   <= CONWAY_SURVIVE;
            prev_row    <= '0;
            cur_row     <= '0;
            row_cnt     <= '0;
            out_row     <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            gen_done    <= 1'b0;
            alive_count <= '0;
            stable      <= 1'b0;
        end else begin
            gen_done <= last_hs;
            if (start_go) begin
                birth_q     <= birth_mask;
                survive_q   <= survive_mask;
                prev_row    <= '0;
                row_cnt     <= '0;
                alive_count <= '0;
                stable      <= 1'b1;
            end
            if (fill_acc) begin
                cur_row <= in_row;
                row_cnt <= row_cnt + RW'(1);
            end
            if (load_run || load_drain) begin
                out_row     <= new_row;
                out_valid   <= 1'b1;
                out_last    <= load_drain;
                alive_count <= alive_count + CW'(popcount(POP_MAX'(new_row)));
                if (new_row != cur_row) stable <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (load_run) begin
                prev_row <= cur_row;
                cur_row  <= in_row;
                row_cnt  <= row_cnt + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_life_row_engine.sv
// tb/tb_life_row_engine.sv - self-checking bench for life_row_engine (8x4, zero-edge and torus instances)
module tb_life_row_engine;
    import life_pkg::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CW = $clog2(W*H+1);

    typedef logic [H-1:0][W-1:0] frame_t;
    typedef struct packed {
        frame_t          rows;
        logic [8:0]      birth;
        logic [8:0]      survive;
        frame_t          exp0;
        frame_t          exp1;
        logic [CW-1:0]   alive0;
        logic [CW-1:0]   alive1;
        logic            stable0;
        logic            stable1;
        logic            mid_start;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    birth_mask = '0;
    logic [8:0]    survive_mask = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_row = '0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0, out_last0, busy0, gen_done0, stable0;
    logic [W-1:0]  out_row0;
    logic [CW-1:0] alive0;
    logic          in_ready1, out_valid1, out_last1, busy1, gen_done1, stable1;
    logic [W-1:0]  out_row1;
    logic [CW-1:0] alive1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    life_row_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .birth_mask(birth_mask), .survive_mask(survive_mask),
        .in_valid(in_valid), .in_ready(in_ready0), .in_row(in_row),
        .out_valid(out_valid0), .out_ready(out_ready), .out_row(out_row0), .out_last(out_last0),
        .busy(busy0), .gen_done(gen_done0), .alive_count(alive0), .stable(stable0)
    );

    life_row_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .birth_mask(birth_mask), .survive_mask(survive_mask),
        .in_valid(in_valid), .in_ready(in_ready1), .in_row(in_row),
        .out_valid(out_valid1), .out_ready(out_ready), .out_row(out_row1), .out_last(out_last1),
        .busy(busy1), .gen_done(gen_done1), .alive_count(alive1), .stable(stable1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [W-1:0] r0, input logic [W-1:0] r1,
                                  input logic [W-1:0] r2, input logic [W-1:0] r3);
        frame_t f;
        f[0] = r0; f[1] = r1; f[2] = r2; f[3] = r3;
        return f;
    endfunction

    // Reference: count the 8 neighbours of every cell directly on the grid.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] above, input logic [W-1:0] here,
                                              input logic [W-1:0] below, input bit wrap,
                                              input logic [8:0] b, input logic [8:0] s);
        logic [W-1:0] rr [3];
        logic [W-1:0] res;
        int n, cc;
        rr[0] = above; rr[1] = here; rr[2] = below;
        for (int col = 0; col < W; col++) begin
            n = 0;
            for (int dr = 0; dr < 3; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr == 1 && dc == 0) continue;
                    cc = col + dc;
                    if (cc < 0 || cc >= W) begin
                        if (!wrap) continue;
                        cc = (cc + W) % W;
                    end
                    n += int'(rr[dr][cc]);
                end
            end
            res[col] = here[col] ? s[n] : b[n];
        end
        return res;
    endfunction

    task automatic ref_gen(input frame_t rows, input bit wrap, input logic [8:0] b, input logic [8:0] s,
                           output frame_t o, output logic [CW-1:0] alive, output logic st);
        logic [W-1:0] above, below;
        int a;
        a  = 0;
        st = 1'b1;
        for (int r = 0; r < H; r++) begin
            above = '0;
            below = '0;
            if (r > 0)     above = rows[r-1];
            if (r < H - 1) below = rows[r+1];
            o[r] = ref_next(above, rows[r], below, wrap, b, s);
            a += $countones(o[r]);
            if (o[r] != rows[r]) st = 1'b0;
        end
        alive = CW'(a);
    endtask

    task automatic run_gen(input vec_t v, input int hold, input int pct, input string tag);
        frame_t g0, g1;
        logic [H-1:0] lastf;
        logic [W-1:0] held;
        logic held_last;
        int idx, nout, first_acc, last_hs, cyc;
        bit done, stall;
        idx = 0; nout = 0; first_acc = -1; last_hs = -1; cyc = 0; done = 0; stall = 0;
        g0 = 'x; g1 = 'x; lastf = 'x; held = '0; held_last = 1'b0;

        @(negedge clk);
        start = 1'b1; birth_mask = v.birth; survive_mask = v.survive;
        in_valid = 1'b1; in_row = '1; out_ready = 1'b0;
        #1 chk({tag, " in_ready_at_start"}, in_ready0, 0);
        @(negedge clk);
        while (!done && cyc < 200) begin
            out_ready = (cyc >= hold) && ($urandom_range(99) < pct);
            in_valid  = (idx < H);
            in_row    = (idx < H) ? v.rows[idx] : '0;
            if (v.mid_start && cyc == 2) begin
                start = 1'b1; birth_mask = 9'h1FF; survive_mask = 9'h000;
            end else begin
                start = 1'b0;
            end
            #1;
            if (cyc == 0) chk({tag, " busy_in_fill"}, busy0, 1);
            if (stall) begin
                chk({tag, " hold_valid"}, out_valid0, 1);
                chk({tag, " hold_row"}, out_row0, held);
                chk({tag, " hold_last"}, out_last0, held_last);
            end
            stall = out_valid0 && !out_ready;
            if (stall) begin
                held = out_row0; held_last = out_last0;
                chk({tag, " in_ready_stalled"}, in_ready0, 0);
            end
            if (in_valid && in_ready0) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
            end
            if (out_valid0 && out_ready) begin
                if (nout < H) begin
                    g0[nout] = out_row0; g1[nout] = out_row1; lastf[nout] = out_last0;
                end
                nout++;
                last_hs = cyc;
            end
            if (gen_done0) begin
                chk({tag, " busy_at_done"}, busy0, 0);
                chk({tag, " done_wrap"}, gen_done1, 1);
                done = 1;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: gen_done not seen after %0d cycles", tag, cyc);
        end
        #1 chk({tag, " done_one_pulse"}, gen_done0, 0);
        chk({tag, " row_count"}, nout, H);
        for (int r = 0; r < H; r++) begin
            chk($sformatf("%s row%0d_nowrap", tag, r), g0[r], v.exp0[r]);
            chk($sformatf("%s row%0d_wrap", tag, r), g1[r], v.exp1[r]);
            chk($sformatf("%s row%0d_last", tag, r), lastf[r], (r == H - 1));
        end
        chk({tag, " alive_nowrap"}, alive0, v.alive0);
        chk({tag, " alive_wrap"}, alive1, v.alive1);
        chk({tag, " stable_nowrap"}, stable0, v.stable0);
        chk({tag, " stable_wrap"}, stable1, v.stable1);
        if (hold == 0 && pct == 100)
            chk({tag, " latency"}, last_hs - first_acc + 1, H + 2);
        out_ready = 1'b0;
    endtask

    vec_t vecs [4];
    vec_t rv;

    initial begin
        vecs[0] = '{rows: mk(8'h00, 8'h1C, 8'h00, 8'h00), birth: CONWAY_BIRTH, survive: CONWAY_SURVIVE,
                    exp0: mk(8'h08, 8'h08, 8'h08, 8'h00), exp1: mk(8'h08, 8'h08, 8'h08, 8'h00),
                    alive0: 3, alive1: 3, stable0: 0, stable1: 0, mid_start: 0};
        vecs[1] = '{rows: mk(8'h00, 8'h18, 8'h18, 8'h00), birth: CONWAY_BIRTH, survive: CONWAY_SURVIVE,
                    exp0: mk(8'h00, 8'h18, 8'h18, 8'h00), exp1: mk(8'h00, 8'h18, 8'h18, 8'h00),
                    alive0: 4, alive1: 4, stable0: 1, stable1: 1, mid_start: 0};
        vecs[2] = '{rows: mk(8'h00, 8'h83, 8'h00, 8'h00), birth: CONWAY_BIRTH, survive: CONWAY_SURVIVE,
                    exp0: mk(8'h00, 8'h00, 8'h00, 8'h00), exp1: mk(8'h01, 8'h01, 8'h01, 8'h00),
                    alive0: 0, alive1: 3, stable0: 0, stable1: 0, mid_start: 0};
        vecs[3] = '{rows: mk(8'hA5, 8'h3C, 8'hFF, 8'h01), birth: 9'h000, survive: 9'h1FF,
                    exp0: mk(8'hA5, 8'h3C, 8'hFF, 8'h01), exp1: mk(8'hA5, 8'h3C, 8'hFF, 8'h01),
                    alive0: 17, alive1: 17, stable0: 1, stable1: 1, mid_start: 1};

        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", out_valid0, 0);
        chk("reset out_row", out_row0, 0);
        chk("reset busy", busy0, 0);
        chk("reset alive", alive0, 0);
        chk("reset stable", stable0, 0);
        chk("reset in_ready", in_ready0, 0);
        chk("reset stable_wrap", stable1, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_gen(vecs[i], 0, 100, $sformatf("vec%0d", i));

        run_gen(vecs[0], 8, 100, "backpressure");

        // Abort a blinker generation after its first output row is loaded.
        @(negedge clk);
        start = 1'b1; birth_mask = CONWAY_BIRTH; survive_mask = CONWAY_SURVIVE;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_row = 8'h00; out_ready = 1'b0;
        @(negedge clk);
        in_row = 8'h1C;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("midreset pre_valid", out_valid0, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid0, 0);
        chk("midreset out_row", out_row0, 0);
        chk("midreset busy", busy0, 0);
        chk("midreset alive", alive0, 0);
        chk("midreset stable", stable0, 0);
        chk("midreset busy_wrap", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_gen(vecs[0], 0, 100, "after_reset");

        for (int i = 0; i < 16; i++) begin
            for (int r = 0; r < H; r++) rv.rows[r] = 8'($urandom);
            if (i % 3 == 0) begin
                rv.birth = 9'($urandom); rv.survive = 9'($urandom);
            end else begin
                rv.birth = CONWAY_BIRTH; rv.survive = CONWAY_SURVIVE;
            end
            rv.mid_start = (i % 4 == 1);
            ref_gen(rv.rows, 1'b0, rv.birth, rv.survive, rv.exp0, rv.alive0, rv.stable0);
            ref_gen(rv.rows, 1'b1, rv.birth, rv.survive, rv.exp1, rv.alive1, rv.stable1);
            run_gen(rv, int'($urandom_range(3)), (i % 2 == 0) ? 100 : 30 + int'($urandom_range(60)),
                    $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/life_row_engine.md
# life_row_engine

Streaming next-generation engine for cellular-automaton grids. It accepts one WIDTH-cell row per handshake and holds a three-row window (previous, current, incoming). It emits each next-generation row through a one-slot registered output, under a run-time birth/survive rule. It replaces the single-cell combinational rule evaluator: it sits between the grid memory reader and writer, and reports population and stability per generation.

## Interface
- WIDTH, 64: cells per row; WIDTH ≥ 3.
- HEIGHT, 32: rows per generation; HEIGHT ≥ 2.
- WRAP, 0: 1 = horizontal torus (column 0 and column WIDTH-1 are neighbours); 0 = dead columns outside the row. Vertical boundary is always dead.
- Reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a generation; latches the masks.
- birth_mask  in  9  bit n set: a dead cell with n live neighbours is born.
- survive_mask  in  9  bit n set: a live cell with n live neighbours survives.
- in_valid / in_ready  in / out  1  input row handshake.
- in_row  in  WIDTH  current-generation row; bit i is column i.
- out_valid / out_ready  out / in  1  output row handshake.
- out_row  out  WIDTH  next-generation row.
- out_last  out  1  marks output row HEIGHT-1.
- busy  out  1  high from start until the final output handshake.
- gen_done  out  1  one-cycle pulse when the generation completes.
- alive_count  out  $clog2(WIDTH*HEIGHT+1)  live cells in the emitted generation.
- stable  out  1  every output row equalled its input row.

## Operation
- **States:** IDLE, FILL, RUN, DRAIN, LAST.
- **IDLE:** in_ready=0.
  - start=1 → FILL.
  - On that transition: latch the masks, zero prev, clear the row counter and alive_count, set stable=1.
- **start outside IDLE:** ignored.
- **FILL:** in_ready=1. On accept, cur←in_row, then → RUN.
- **RUN:** in_ready = !out_valid || out_ready.
  - On accepting row k (k = 1..HEIGHT-1): out_row←nextgen(prev, cur, in_row), prev←cur, cur←in_row.
  - out_valid←1, out_last←0.
  - alive_count += popcount(new row).
  - stable cleared if the new row ≠ cur.
  - After k = HEIGHT-1 → DRAIN.
- **DRAIN:** in_ready=0.
  - When !out_valid || out_ready: load nextgen(prev, cur, 0), set out_last=1, update count and stable, then → LAST.
- **LAST:** on out_valid && out_ready → IDLE. gen_done pulses the following cycle and busy drops in that same cycle.
- **Output hold:** out_valid with out_ready=0 holds out_row and out_last stable.
- **Result hold:** alive_count and stable hold after gen_done until the next start.
- **Rule per cell:** n = sum of the 8 neighbours. The next state is survive_mask[n] if the cell is live, else birth_mask[n]. The sum is 4 bits wide, range 0..8.
- **Reset:** reset in any state returns to IDLE and discards the partial generation. All outputs go to 0, including stable.

## Timing
- An output row loads in the same clock edge as the input accept that completes its window.
- out_valid is asserted the cycle after row 1 is accepted (output row 0).
- Sustained throughput is 1 row/cycle when out_ready=1.
- A generation takes HEIGHT+2 cycles from the first accept to the final handshake, with no backpressure.
- in_ready depends combinationally on out_ready in RUN. It is registered nowhere else.
- start and in_valid in the same cycle: the row is not accepted, because in_ready=0 in IDLE.

## Structure
- **life_pkg:** state enum; default Conway masks CONWAY_BIRTH=9'b000001000 and CONWAY_SURVIVE=9'b000001100; popcount function.
- **life_rule_cell:** sub-module that computes one cell from 9 bits plus the masks. It is instantiated WIDTH times via generate. Edge taps select the wrap or zero neighbour per WRAP.

## Test plan
All scenarios use WIDTH=8, HEIGHT=4, Conway masks unless stated.
- **Blinker:** rows {0, 8'b00011100, 0, 0} → outputs {8'b00001000 ×3, 0}; out_last on row 3; alive_count=3; stable=0.
- **Block still life:** rows {0, 8'b00011000, 8'b00011000, 0} → identical outputs; alive_count=4; stable=1; gen_done one pulse.
- **Wrap:** row1=8'b10000011, others 0.
  - WRAP=1 → rows 0..2 = 8'b00000001, alive_count=3.
  - WRAP=0 → all zero, alive_count=0.
- **Backpressure:** out_ready=0 from the start.
  - in_ready drops after row 1 is accepted.
  - out_row holds 8'b00001000 (blinker).
  - Release out_ready → remaining rows arrive in order with no loss.
- **Identity rule and start while busy:** birth_mask=0, survive_mask=9'h1FF → out = in, stable=1. A start pulse mid-frame is ignored.
- **Mid-frame reset:** rst_n pulses low mid-frame.
  - Outputs are 0 and busy is 0 immediately.
  - A new start then yields a correct blinker generation.
